// File: rtl/e_stage_pipe_reg.sv
// ----------------------------------------------------------------------------
// e_stage_pipe_reg
// Decode-to-execute pipeline register for the Y86 pipeline. On each rising
// edge it holds (stall), loads a NOP bubble, or captures the D-stage fields.
// It also provides a valid flag, a sticky stall+bubble conflict flag and
// saturating stall/bubble performance counters.
//
// Ports:
//   clk, reset_n           clock, asynchronous active-low reset
//   E_stall, E_bubble      hazard control (stall has priority)
//   cnt_clr                synchronous clear of both counters
//   d_*                    decoded instruction fields from the D stage
//   E_*                    registered instruction fields for the E stage
//   E_valid                1 = E holds an instruction loaded from D
//   ctl_err                sticky: stall and bubble were requested together
//   stall_cnt, bubble_cnt  saturating performance counters
// ----------------------------------------------------------------------------
module e_stage_pipe_reg #(
  parameter int unsigned WORD_W = 64,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              E_stall,
  input  logic              E_bubble,
  input  logic              cnt_clr,
  input  logic [3:0]        d_stat,
  input  logic [3:0]        d_icode,
  input  logic [3:0]        d_ifun,
  input  logic [3:0]        d_srcA,
  input  logic [3:0]        d_srcB,
  input  logic [3:0]        d_dstE,
  input  logic [3:0]        d_dstM,
  input  logic [WORD_W-1:0] d_valA,
  input  logic [WORD_W-1:0] d_valB,
  input  logic [WORD_W-1:0] d_valC,
  output logic [3:0]        E_stat,
  output logic [3:0]        E_icode,
  output logic [3:0]        E_ifun,
  output logic [3:0]        E_srcA,
  output logic [3:0]        E_srcB,
  output logic [3:0]        E_dstE,
  output logic [3:0]        E_dstM,
  output logic [WORD_W-1:0] E_valA,
  output logic [WORD_W-1:0] E_valB,
  output logic [WORD_W-1:0] E_valC,
  output logic              E_valid,
  output logic              ctl_err,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam logic [3:0]       STAT_AOK  = 4'h1;
  localparam logic [3:0]       ICODE_NOP = 4'h1;
  localparam logic [3:0]       IFUN_NONE = 4'h0;
  localparam logic [3:0]       REG_NONE  = 4'hF;
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  // A bubble is only loaded when not stalled; a conflict resolves to HOLD.
  logic do_bubble;
  logic conflict;

  assign do_bubble = ~E_stall & E_bubble;
  assign conflict  = E_stall & E_bubble;

  // Pipeline payload: hold / bubble / load.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      E_stat  <= STAT_AOK;
      E_icode <= ICODE_NOP;
      E_ifun  <= IFUN_NONE;
      E_srcA  <= REG_NONE;
      E_srcB  <= REG_NONE;
      E_dstE  <= REG_NONE;
      E_dstM  <= REG_NONE;
      E_valA  <= '0;
      E_valB  <= '0;
      E_valC  <= '0;
      E_valid <= 1'b0;
    end else if (!E_stall) begin
      if (E_bubble) begin
        E_stat  <= STAT_AOK;
        E_icode <= ICODE_NOP;
        E_ifun  <= IFUN_NONE;
        E_srcA  <= REG_NONE;
        E_srcB  <= REG_NONE;
        E_dstE  <= REG_NONE;
        E_dstM  <= REG_NONE;
        E_valA  <= '0;
        E_valB  <= '0;
        E_valC  <= '0;
        E_valid <= 1'b0;
      end else begin
        E_stat  <= d_stat;
        E_icode <= d_icode;
        E_ifun  <= d_ifun;
        E_srcA  <= d_srcA;
        E_srcB  <= d_srcB;
        E_dstE  <= d_dstE;
        E_dstM  <= d_dstM;
        E_valA  <= d_valA;
        E_valB  <= d_valB;
        E_valC  <= d_valC;
        E_valid <= 1'b1;
      end
    end
  end

  // Sticky conflict flag; only reset clears it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctl_err <= 1'b0;
    end else if (conflict) begin
      ctl_err <= 1'b1;
    end
  end

  // Saturating counters; clear wins over increment.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else if (cnt_clr) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (E_stall && (stall_cnt != CNT_MAX)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (do_bubble && (bubble_cnt != CNT_MAX)) begin
        bubble_cnt <= bubble_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/e_stage_pipe_reg.md
# e_stage_pipe_reg

Parametrised decode-to-execute pipeline register for the Y86 pipeline, the successor to the fixed-width E register. It captures the decoded instruction fields and status from the D stage on each clock. It also supports stall (hold), bubble (inject NOP), a valid flag, a sticky control-conflict flag and saturating stall/bubble performance counters for the hazard unit and debug.

## Interface
Parameters:
- WORD_W, 64, width of valA/valB/valC datapath words
- CNT_W, 16, width of each performance counter

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- E_stall  in  1  hold current E contents
- E_bubble  in  1  load NOP bubble instead of D-stage fields
- cnt_clr  in  1  synchronous clear of both counters
- d_stat  in  4  instruction status (1=AOK, 2=HLT, 3=ADR, 4=INS)
- d_icode, d_ifun  in  4 each  instruction code / function
- d_srcA, d_srcB, d_dstE, d_dstM  in  4 each  register IDs (4'hF = none)
- d_valA, d_valB, d_valC  in  WORD_W each  operand values
- E_stat, E_icode, E_ifun, E_srcA, E_srcB, E_dstE, E_dstM  out  4 each  registered fields
- E_valA, E_valB, E_valC  out  WORD_W each  registered operands
- E_valid  out  1  1 = E holds an instruction loaded from D; 0 = bubble/reset content
- ctl_err  out  1  sticky: E_stall and E_bubble were asserted together
- stall_cnt  out  CNT_W  cycles with E_stall=1
- bubble_cnt  out  CNT_W  cycles in which a bubble was loaded

## Operation
- Bubble value: stat=4'h1, icode=4'h1 (nop), ifun=0, valA/valB/valC=0 (full WORD_W), srcA/srcB/dstE/dstM=4'hF, E_valid=0.
- Reset (reset_n=0, asynchronous): all E_* fields take the bubble value. E_valid=0, ctl_err=0, stall_cnt=0, bubble_cnt=0. Reset is held while low; reset mid-stall discards the held instruction.
- Each rising edge, there are three mutually exclusive actions, in priority order:
  - HOLD (E_stall=1): all E_* fields and E_valid are unchanged.
  - BUBBLE (E_stall=0, E_bubble=1): load the bubble value.
  - LOAD (both 0): load every d_* field into the matching E_* field; E_valid=1.
- Conflict: E_stall=1 and E_bubble=1 in the same cycle is treated as HOLD and sets ctl_err=1. ctl_err stays set until reset.
- stall_cnt: +1 on every edge with E_stall=1, including conflict cycles.
- bubble_cnt: +1 on every edge where a BUBBLE action occurs.
- Both counters saturate at 2^CNT_W-1; no wrap.
- cnt_clr=1: both counters become 0 on that edge, overriding any increment in the same cycle. E_* fields and ctl_err are unaffected.
- d_stat is carried unchanged; the block does not act on non-AOK status.

## Timing
- Latency: exactly 1 cycle from d_* to E_* on LOAD. All outputs are registered with no combinational path from inputs.
- Control inputs are sampled at the rising edge only; they must be stable around the edge.
- Counters update on the same edge as the action they count. The new value is visible in the cycle after the action.
- reset_n assertion takes effect immediately with no clock required. Deassertion must be synchronous to clk; the first action occurs on the first rising edge with reset_n=1.

## Test plan
- Reset: drive reset_n=0 mid-cycle with E_valid=1 -> immediately E_icode=1, E_dstE=4'hF, E_valA=0, E_stat=1, E_valid=0, counters=0, ctl_err=0.
- Load: stall=0, bubble=0, d_icode=4'h6, d_ifun=1, d_valA=64'h5, d_valB=64'hA, d_dstE=3 -> next cycle E_icode=6, E_ifun=1, E_valA=5, E_valB=10, E_dstE=3, E_valid=1; counters remain 0.
- Stall: load icode=4'h3, then E_stall=1 for 3 cycles while d_icode=4'h7 -> E_icode stays 3 and E_valid stays 1 throughout; stall_cnt=3; after the stall drops, E_icode=7 one cycle later.
- Bubble: E_bubble=1 for 2 cycles after a valid load -> E_icode=1, E_srcA=4'hF, E_valC=0, E_valid=0; bubble_cnt=2.
- Conflict: E_stall=1 and E_bubble=1 for 1 cycle -> E_* held; ctl_err=1, stall_cnt +1, bubble_cnt unchanged; ctl_err stays 1 after the inputs drop until reset.
- Saturation/clear: CNT_W=2, E_stall=1 for 5 cycles -> stall_cnt=3 after cycle 3 and stays 3. Then cnt_clr=1 with E_stall=1 -> stall_cnt=0 next cycle and 1 the cycle after.
